instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Writer side of the instruction memory. Accepts a byte stream (UART/debug bridge, valid/ready)
//  carrying a length header plus little-endian 32-bit words. Writes each word into the instruction
//  RAM at consecutive word-aligned byte addresses. Holds the processor in reset until a load completes.
//  Replaces hard-coded program images with runtime loading.
// PARAMETERS
//  DEPTH   101  instruction memory size in words; headers with length > DEPTH are rejected
//  CNT_W   16   width of the length header and word counters
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  reset_n       in   1      asynchronous active-low reset
//  start         in   1      begin a load (sampled in IDLE, DONE, ERR; ignored otherwise)
//  in_valid      in   1      byte available on in_data
//  in_data       in   8      stream byte
//  in_ready      out  1      loader can take a byte; transfer when in_valid & in_ready
//  mem_we        out  1      one-cycle write strobe to instruction RAM
//  mem_a         out  32     write byte address = word_index<<2, bits [1:0] always 0
//  mem_wd        out  32     write data, assembled little-endian
//  cpu_hold      out  1      keep CPU in reset; low only in DONE
//  busy          out  1      load in progress (LEN_LO..WRITE)
//  done          out  1      last load finished successfully (level)
//  error         out  1      last load rejected (level)
//  words_loaded  out  CNT_W  words written in current/last load
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; in_ready=0, mem_we=0, mem_a=0, mem_wd=0, cpu_hold=1,
//   busy=0, done=0, error=0, words_loaded=0, byte index=0. RAM is never written during reset.
//  States: IDLE, LEN_LO, LEN_HI, BYTE, WRITE, DONE, ERR.
//  IDLE/DONE/ERR + start -> LEN_LO. Clear done, error, words_loaded and word_index.
//  LEN_LO: in_ready=1. On transfer, len[7:0]=in_data -> LEN_HI.
//  LEN_HI: in_ready=1. On transfer, len[15:8]=in_data, then:
//   - len==0        -> DONE
//   - len>DEPTH     -> ERR
//   - otherwise     -> BYTE, with byte index b=0
//  BYTE: in_ready=1. On transfer, mem_wd[8*b+:8]=in_data and b++.
//   - Transfer with b==3 -> WRITE.
//   - in_valid low stalls indefinitely with no timeout.
//  WRITE: in_ready=0. mem_we=1 for exactly one cycle, mem_a=word_index<<2, mem_wd stable.
//   - Next cycle: words_loaded++ and word_index++.
//   - Then -> DONE if word_index+1==len, else -> BYTE with b=0.
//  Per-word latency: 4 accepted bytes + 1 write cycle. Max throughput is 1 word per 5 clocks.
//  DONE: done=1, cpu_hold=0, in_ready=0. ERR: error=1, cpu_hold=1, in_ready=0, no writes issued.
//  mem_we is 0 outside WRITE; mem_a/mem_wd hold their last value.
//  start while busy: ignored. Stream bytes arriving in IDLE/DONE/ERR: not accepted (in_ready=0).
//  len==DEPTH is legal and the last write goes to (DEPTH-1)<<2. Counters never wrap.
//  Async reset mid-load aborts immediately. Words already written stay in RAM, cpu_hold returns to 1.
// TESTING
//  1. Reset, start, bytes 01 00 78 00 A0 E3 -> one mem_we, mem_a=0, mem_wd=E3A00078; done=1,
//     cpu_hold=0, words_loaded=1.
//  2. len=3 with words E3A00078, E3A01E4B, E3A03000 and in_valid toggled randomly -> writes at
//     addresses 0,4,8 in order; exactly 3 mem_we pulses; each pulse 1 cycle.
//  3. Header 66 00 (102>DEPTH) -> ERR, error=1, no mem_we, in_ready=0, cpu_hold=1;
//     then start + valid load -> error clears, done=1.
//  4. Header 00 00 -> DONE in cycle after LEN_HI transfer, no mem_we; header 65 00 (101) ->
//     last write mem_a=0x190.
//  5. start pulsed during BYTE -> ignored, load completes normally; in_valid held high in DONE ->
//     no byte consumed.
//  6. reset_n low after 2nd of 3 words -> all outputs at reset values same cycle (async);
//     restart reloads from mem_a=0.

Source files
------------

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Writer side of the instruction memory. A byte stream (valid/ready) delivers
//   a 16-bit little-endian word count followed by that many little-endian
//   32-bit words. Each word is written to consecutive word-aligned byte
//   addresses of the instruction RAM. The CPU is held in reset until a load
//   completes successfully.
//
// Ports
//   clk           in   1      system clock, rising edge
//   reset_n       in   1      asynchronous active-low reset
//   start         in   1      begin a load (honoured in IDLE, DONE, ERR)
//   in_valid      in   1      byte available on in_data
//   in_data       in   8      stream byte
//   in_ready      out  1      loader accepts a byte this cycle
//   mem_we        out  1      one-cycle RAM write strobe
//   mem_a         out  32     RAM byte address (word_index << 2)
//   mem_wd        out  32     RAM write data, assembled little-endian
//   cpu_hold      out  1      hold CPU in reset (low only in DONE)
//   busy          out  1      load in progress
//   done          out  1      last load finished successfully
//   error         out  1      last load rejected (length > DEPTH)
//   words_loaded  out  CNT_W  words written in the current/last load
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int DEPTH = 101,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_BYTE   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   len_r;
    logic [CNT_W-1:0]   word_idx_r;
    logic [1:0]         byte_idx_r;
    logic               xfer_s;
    logic [CNT_W-1:0]   len_full_s;
    logic [31:0]        word_addr_s;
    logic               last_word_s;

    // in_ready is a registered decode of the state, so a handshake seen here
    // always belongs to the state currently held in state_r.
    assign xfer_s      = in_valid & in_ready;
    // Full header once the high byte arrives (low byte already captured).
    assign len_full_s  = CNT_W'({in_data, len_r[7:0]});
    assign word_addr_s = 32'(word_idx_r) << 3'd2;
    assign last_word_s = ((word_idx_r + ONE_C) == len_r);

    // Next-state decode for the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next_s = ST_LEN_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) begin
                    state_next_s = ST_LEN_HI;
                end else begin
                    state_next_s = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (!xfer_s) begin
                    state_next_s = ST_LEN_HI;
                end else if (len_full_s == ZERO_C) begin
                    state_next_s = ST_DONE;
                end else if (len_full_s > DEPTH_C) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_BYTE;
                end
            end
            ST_BYTE: begin
                if (xfer_s && (byte_idx_r == 2'd3)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_BYTE;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BYTE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state, so
    // every status flag lines up with the state it describes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            in_ready <= (state_next_s == ST_LEN_LO) || (state_next_s == ST_LEN_HI) ||
                        (state_next_s == ST_BYTE);
            mem_we   <= (state_next_s == ST_WRITE);
            cpu_hold <= (state_next_s != ST_DONE);
            busy     <= (state_next_s == ST_LEN_LO) || (state_next_s == ST_LEN_HI) ||
                        (state_next_s == ST_BYTE)   || (state_next_s == ST_WRITE);
            done     <= (state_next_s == ST_DONE);
            error    <= (state_next_s == ST_ERR);
        end
    end

    // Datapath: header capture, byte assembly, write address and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r        <= ZERO_C;
            word_idx_r   <= ZERO_C;
            words_loaded <= ZERO_C;
            byte_idx_r   <= 2'd0;
            mem_a        <= 32'd0;
            mem_wd       <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        words_loaded <= ZERO_C;
                        word_idx_r   <= ZERO_C;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer_s) begin
                        len_r[7:0] <= in_data;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer_s) begin
                        len_r      <= len_full_s;
                        byte_idx_r <= 2'd0;
                    end
                end
                ST_BYTE: begin
                    if (xfer_s) begin
                        mem_wd[{byte_idx_r, 3'b000} +: 8] <= in_data;
                        // Two-bit index wraps back to 0 ready for the next word.
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            mem_a <= word_addr_s;
                        end
                    end
                end
                ST_WRITE: begin
                    words_loaded <= words_loaded + ONE_C;
                    word_idx_r   <= word_idx_r + ONE_C;
                end
                default: begin
                    len_r <= len_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int DEPTH = 101;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    instr_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] len;
        int          gap;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_words;
        bit          mid_start;
    } vec_t;

    // Captured RAM writes (one entry per strobe cycle) and strobe-width tracking.
    logic [31:0] wr_a_q[$];
    logic [31:0] wr_d_q[$];
    int          long_pulses = 0;
    logic        prev_we = 1'b0;
    logic [31:0] load_words[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wr_a_q.push_back(mem_a);
            wr_d_q.push_back(mem_wd);
            if (prev_we) long_pulses <= long_pulses + 1;
        end
        prev_we <= mem_we;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_a"}, mem_a, 32'd0);
        chk({tag, " mem_wd"}, mem_wd, 32'd0);
        chk({tag, " cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
        chk({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    // Offer one byte after a random idle gap; ok=1 once it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bit rdy;
        int n;
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap)) tick();
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            ok = rdy;
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full load of len words from load_words, then compare against expectations.
    task automatic run_load(input string name, input logic [15:0] len, input int gap,
                            input logic exp_done, input logic exp_err,
                            input logic [15:0] exp_words, input bit mid_start);
        bit ok;
        bit all_ok;
        int n;
        logic [31:0] w;
        wr_a_q.delete();
        wr_d_q.delete();
        long_pulses = 0;
        pulse_start();
        chk({name, " start busy"}, 32'(busy), 32'd1);
        chk({name, " start clears done"}, 32'(done), 32'd0);
        chk({name, " start clears error"}, 32'(error), 32'd0);
        chk({name, " start clears count"}, 32'(words_loaded), 32'd0);
        all_ok = 1'b1;
        send_byte(len[7:0], gap, ok);
        all_ok &= ok;
        send_byte(len[15:8], gap, ok);
        all_ok &= ok;
        if (len == 16'd0) chk({name, " zero len done next cycle"}, 32'(done), 32'd1);
        if (len > 16'(DEPTH)) begin
            chk({name, " err next cycle"}, 32'(error), 32'd1);
            chk({name, " err in_ready"}, 32'(in_ready), 32'd0);
        end
        if (len != 16'd0 && len <= 16'(DEPTH)) begin
            for (int i = 0; i < int'(len); i++) begin
                w = load_words[i];
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], gap, ok);
                    all_ok &= ok;
                    if (mid_start && i == 0 && k == 1) pulse_start();
                end
            end
        end
        chk({name, " bytes accepted"}, 32'(all_ok), 32'd1);
        n = 0;
        while (!(done || error) && n < 100) begin
            tick();
            n++;
        end
        chk({name, " done"}, 32'(done), 32'(exp_done));
        chk({name, " error"}, 32'(error), 32'(exp_err));
        chk({name, " cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " words_loaded"}, 32'(words_loaded), 32'(exp_words));
        chk({name, " write count"}, wr_a_q.size(), 32'(exp_words));
        for (int i = 0; i < int'(exp_words) && i < wr_a_q.size(); i++) begin
            chk({name, " write addr"}, wr_a_q[i], 32'(i * 4));
            chk({name, " write data"}, wr_d_q[i], load_words[i]);
        end
        chk({name, " strobe width"}, 32'(long_pulses), 32'd0);
    endtask

    task automatic fill_words(input int n);
        load_words.delete();
        for (int i = 0; i < n; i++) load_words.push_back($urandom());
        if (n > 0) load_words[0] = 32'hE3A00078;
        if (n > 1) load_words[1] = 32'hE3A01E4B;
        if (n > 2) load_words[2] = 32'hE3A03000;
    endtask

    vec_t vecs[8];

    initial begin
        logic [15:0] rlen;
        logic        r_err;
        int          n;
        bit          ok;
        logic [15:0] wl_before;

        vecs[0] = '{16'd1,      0, 1'b1, 1'b0, 16'd1,   1'b0};
        vecs[1] = '{16'd3,      2, 1'b1, 1'b0, 16'd3,   1'b0};
        vecs[2] = '{16'd102,    0, 1'b0, 1'b1, 16'd0,   1'b0};
        vecs[3] = '{16'd2,      1, 1'b1, 1'b0, 16'd2,   1'b0};
        vecs[4] = '{16'd0,      0, 1'b1, 1'b0, 16'd0,   1'b0};
        vecs[5] = '{16'd101,    0, 1'b1, 1'b0, 16'd101, 1'b0};
        vecs[6] = '{16'hFFFF,   0, 1'b0, 1'b1, 16'd0,   1'b0};
        vecs[7] = '{16'd2,      1, 1'b1, 1'b0, 16'd2,   1'b1};

        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #12;
        chk_reset("reset");
        reset_n = 1'b1;
        tick();

        // Single-word load: 01 00 78 00 A0 E3.
        fill_words(1);
        run_load("basic", 16'd1, 0, 1'b1, 1'b0, 16'd1, 1'b0);
        if (wr_d_q.size() > 0) chk("basic word", wr_d_q[0], 32'hE3A00078);

        // Table-driven loads.
        foreach (vecs[v]) begin
            fill_words(int'(vecs[v].len <= 16'(DEPTH) ? vecs[v].len : 16'd0));
            run_load($sformatf("vec%0d", v), vecs[v].len, vecs[v].gap, vecs[v].exp_done,
                     vecs[v].exp_err, vecs[v].exp_words, vecs[v].mid_start);
            if (vecs[v].len == 16'd101 && wr_a_q.size() == 101)
                chk("depth last addr", wr_a_q[100], 32'h190);
        end

        // Bytes offered in DONE are never taken.
        wl_before = words_loaded;
        wr_a_q.delete();
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            chk("done in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("done holds", 32'(done), 32'd1);
        chk("done count stable", 32'(words_loaded), 32'(wl_before));
        chk("done no writes", wr_a_q.size(), 32'd0);

        // Randomized loads against the rule-level model.
        for (int r = 0; r < 6; r++) begin
            rlen  = 16'($urandom_range(0, 110));
            r_err = (rlen > 16'(DEPTH));
            fill_words(r_err ? 0 : int'(rlen));
            run_load($sformatf("rand%0d", r), rlen, 2, !r_err, r_err,
                     r_err ? 16'd0 : rlen, 1'b0);
        end

        // Asynchronous reset mid-load, then a fresh load starts at address 0.
        fill_words(3);
        wr_a_q.delete();
        wr_d_q.delete();
        pulse_start();
        send_byte(8'd3, 0, ok);
        send_byte(8'd0, 0, ok);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) send_byte(load_words[i][8*k +: 8], 1, ok);
        end
        n = 0;
        while (wr_a_q.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("pre-reset writes", wr_a_q.size(), 32'd2);
        send_byte(8'hAB, 0, ok);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("async reset");
        #3;
        reset_n = 1'b1;
        tick();
        chk("no write after reset", wr_a_q.size(), 32'd2);
        fill_words(1);
        run_load("restart", 16'd1, 0, 1'b1, 1'b0, 16'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
